// File: rtl/rob_multiport_pkg.sv
// Shared types and widths for the multi-port reorder buffer.
package rob_multiport_pkg;

    localparam int unsigned REG_DATA_W   = 32;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned ARF_ID_W     = 5;
    localparam int unsigned N_ENTRIES_DF = 16;
    localparam int unsigned N_WB_DF      = 3;
    localparam int unsigned N_RD_DF      = 2;
    localparam int unsigned RETIRE_W_DF  = 2;

    typedef struct packed {
        logic                dst_valid;
        logic [ARF_ID_W-1:0] dst_arf_id;
        logic                is_store;
        logic [ADDR_W-1:0]   pc;
    } rob_dispatch_t;

    typedef struct packed {
        logic                  is_executed;
        logic                  br_mispred;
        logic                  dst_valid;
        logic [ARF_ID_W-1:0]   dst_arf_id;
        logic                  is_store;
        logic [ADDR_W-1:0]     pc_npc;
        logic [REG_DATA_W-1:0] reg_data;
    } rob_entry_t;

    typedef struct packed {
        logic                  valid;
        logic                  arf_wr;
        logic [ARF_ID_W-1:0]   arf_id;
        logic [REG_DATA_W-1:0] reg_data;
        logic                  st_commit;
    } rob_retire_t;

endpackage

// File: rtl/rob_multiport_if.sv
// Dispatch / writeback / operand-read / retire bundle of the reorder buffer.
interface rob_multiport_if #(
    parameter int unsigned N_ENTRIES = 16,
    parameter int unsigned N_WB      = 3,
    parameter int unsigned N_RD      = 2,
    parameter int unsigned RETIRE_W  = 2
);
    import rob_multiport_pkg::*;

    localparam int unsigned ROB_ID_W = $clog2(N_ENTRIES);

    logic                                 dispatch_valid;
    logic                                 dispatch_ready;
    logic [ROB_ID_W-1:0]                  dispatch_rob_id;
    rob_dispatch_t                        dispatch_data;

    logic [N_WB-1:0]                      wb_valid;
    logic [N_WB-1:0][ROB_ID_W-1:0]        wb_rob_id;
    logic [N_WB-1:0][REG_DATA_W-1:0]      wb_reg_data;
    logic [N_WB-1:0]                      wb_npc_valid;
    logic [N_WB-1:0]                      wb_npc_mispred;
    logic [N_WB-1:0][ADDR_W-1:0]          wb_npc;

    logic [N_RD-1:0][ROB_ID_W-1:0]        rd_rob_id;
    logic [N_RD-1:0]                      rd_ready;
    logic [N_RD-1:0][REG_DATA_W-1:0]      rd_reg_data;

    logic [RETIRE_W-1:0]                  retire_valid;
    logic [RETIRE_W-1:0]                  retire_arf_wr;
    logic [RETIRE_W-1:0][ARF_ID_W-1:0]    retire_arf_id;
    logic [RETIRE_W-1:0][REG_DATA_W-1:0]  retire_reg_data;
    logic [RETIRE_W-1:0]                  st_commit;
    logic                                 redirect_valid;
    logic [ADDR_W-1:0]                    redirect_pc;

    modport master (
        output dispatch_valid, dispatch_data,
        output wb_valid, wb_rob_id, wb_reg_data, wb_npc_valid, wb_npc_mispred, wb_npc,
        output rd_rob_id,
        input  dispatch_ready, dispatch_rob_id, rd_ready, rd_reg_data,
        input  retire_valid, retire_arf_wr, retire_arf_id, retire_reg_data, st_commit,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  dispatch_valid, dispatch_data,
        input  wb_valid, wb_rob_id, wb_reg_data, wb_npc_valid, wb_npc_mispred, wb_npc,
        input  rd_rob_id,
        output dispatch_ready, dispatch_rob_id, rd_ready, rd_reg_data,
        output retire_valid, retire_arf_wr, retire_arf_id, retire_reg_data, st_commit,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/rob_multiport_wrap_ptr.sv
// Circular-buffer pointer with wrap bit: advances by a variable increment, sync clear on flush.
module rob_multiport_wrap_ptr #(
    parameter int unsigned W     = 5,
    parameter int unsigned INC_W = 2
) (
    input  logic             clk,
    input  logic             rst_aH,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     ptr
);

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH)   ptr <= '0;
        else if (clr) ptr <= '0;
        else          ptr <= ptr + W'(inc);
    end

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer: in-order enqueue, multi-port writeback with read bypass, up to RETIRE_W retires/cycle.
module rob_multiport
    import rob_multiport_pkg::*;
#(
    parameter int unsigned N_ENTRIES = N_ENTRIES_DF,
    parameter int unsigned N_WB      = N_WB_DF,
    parameter int unsigned N_RD      = N_RD_DF,
    parameter int unsigned RETIRE_W  = RETIRE_W_DF
) (
    input  logic           clk,
    input  logic           rst_aH,
    rob_multiport_if.slave bus
);

    localparam int unsigned ROB_ID_W = $clog2(N_ENTRIES);
    localparam int unsigned PTR_W    = ROB_ID_W + 1;
    localparam int unsigned INC_W    = $clog2(RETIRE_W + 1);

    logic [PTR_W-1:0]    head_ptr, tail_ptr, count;
    logic [ROB_ID_W-1:0] head_idx, tail_idx;
    logic                full, fire, redirect;
    logic [ADDR_W-1:0]   redirect_pc;
    logic [INC_W-1:0]    ret_cnt;
    rob_entry_t          entry_q [N_ENTRIES];
    rob_entry_t          entry_d [N_ENTRIES];
    rob_retire_t         ret     [RETIRE_W];

    assign head_idx = head_ptr[ROB_ID_W-1:0];
    assign tail_idx = tail_ptr[ROB_ID_W-1:0];
    assign count    = tail_ptr - head_ptr;
    assign full     = (head_idx == tail_idx) && (head_ptr[ROB_ID_W] != tail_ptr[ROB_ID_W]);
    assign fire     = bus.dispatch_valid && !full && !redirect;

    function automatic logic in_window(input logic [ROB_ID_W-1:0] id,
                                       input logic [ROB_ID_W-1:0] head,
                                       input logic [PTR_W-1:0]    cnt);
        logic [ROB_ID_W-1:0] off;
        off = id - head;
        return PTR_W'(off) < cnt;
    endfunction

    rob_multiport_wrap_ptr #(.W(PTR_W), .INC_W(INC_W)) u_head (
        .clk(clk), .rst_aH(rst_aH), .clr(redirect), .inc(ret_cnt), .ptr(head_ptr)
    );

    rob_multiport_wrap_ptr #(.W(PTR_W), .INC_W(INC_W)) u_tail (
        .clk(clk), .rst_aH(rst_aH), .clr(redirect), .inc(INC_W'(fire)), .ptr(tail_ptr)
    );

    // Retire window: stop at the first unexecuted slot, or just after the first mispredicted one.
    always_comb begin
        rob_entry_t slot;
        logic       blocked;
        blocked     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        ret_cnt     = '0;
        slot        = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            slot   = entry_q[ROB_ID_W'(head_idx + ROB_ID_W'(k))];
            ret[k] = '0;
            if (!blocked && (PTR_W'(k) < count) && slot.is_executed) begin
                ret[k].valid     = 1'b1;
                ret[k].arf_wr    = slot.dst_valid;
                ret[k].arf_id    = slot.dst_arf_id;
                ret[k].reg_data  = slot.reg_data;
                ret[k].st_commit = slot.is_store;
                if (slot.br_mispred) begin
                    redirect    = 1'b1;
                    redirect_pc = slot.pc_npc;
                    blocked     = 1'b1;
                end
            end else begin
                blocked = 1'b1;
            end
            ret_cnt = ret_cnt + INC_W'(ret[k].valid);
        end
    end

    always_comb begin
        bus.retire_valid    = '0;
        bus.retire_arf_wr   = '0;
        bus.retire_arf_id   = '0;
        bus.retire_reg_data = '0;
        bus.st_commit       = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            bus.retire_valid[k]    = ret[k].valid;
            bus.retire_arf_wr[k]   = ret[k].valid & ret[k].arf_wr;
            bus.retire_arf_id[k]   = ret[k].arf_id;
            bus.retire_reg_data[k] = ret[k].reg_data;
            bus.st_commit[k]       = ret[k].valid & ret[k].st_commit;
        end
        bus.redirect_valid  = redirect;
        bus.redirect_pc     = redirect_pc;
        bus.dispatch_ready  = !full && !redirect;
        bus.dispatch_rob_id = tail_idx;
    end

    // Operand read: slot state, overridden by any same-cycle writeback (highest port last).
    always_comb begin
        bus.rd_ready    = '0;
        bus.rd_reg_data = '0;
        for (int r = 0; r < N_RD; r++) begin
            bus.rd_ready[r]    = entry_q[bus.rd_rob_id[r]].is_executed;
            bus.rd_reg_data[r] = entry_q[bus.rd_rob_id[r]].reg_data;
            for (int p = 0; p < N_WB; p++) begin
                if (bus.wb_valid[p] && (bus.wb_rob_id[p] == bus.rd_rob_id[r])) begin
                    bus.rd_ready[r]    = 1'b1;
                    bus.rd_reg_data[r] = bus.wb_reg_data[p];
                end
            end
        end
    end

    // Entry update: flush clears flags; otherwise wb (higher port wins), then enqueue on top.
    always_comb begin
        entry_d = entry_q;
        if (redirect) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                entry_d[i].is_executed = 1'b0;
                entry_d[i].br_mispred  = 1'b0;
            end
        end else begin
            for (int p = 0; p < N_WB; p++) begin
                if (bus.wb_valid[p] && in_window(bus.wb_rob_id[p], head_idx, count)) begin
                    entry_d[bus.wb_rob_id[p]].is_executed = 1'b1;
                    entry_d[bus.wb_rob_id[p]].reg_data    = bus.wb_reg_data[p];
                    if (bus.wb_npc_valid[p]) begin
                        entry_d[bus.wb_rob_id[p]].pc_npc     = bus.wb_npc[p];
                        entry_d[bus.wb_rob_id[p]].br_mispred = bus.wb_npc_mispred[p];
                    end
                end
            end
            if (fire) begin
                entry_d[tail_idx].is_executed = 1'b0;
                entry_d[tail_idx].br_mispred  = 1'b0;
                entry_d[tail_idx].dst_valid   = bus.dispatch_data.dst_valid;
                entry_d[tail_idx].dst_arf_id  = bus.dispatch_data.dst_arf_id;
                entry_d[tail_idx].is_store    = bus.dispatch_data.is_store;
                entry_d[tail_idx].pc_npc      = bus.dispatch_data.pc;
                entry_d[tail_idx].reg_data    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            for (int i = 0; i < N_ENTRIES; i++) entry_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) entry_q[i] <= entry_d[i];
        end
    end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport with a queue-based reference model checked every cycle.
module tb_rob_multiport;
    import rob_multiport_pkg::*;

    localparam int NE = 16;
    localparam int NW = 3;
    localparam int NR = 2;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_chk  = 0;

    rob_multiport_if #(.N_ENTRIES(NE), .N_WB(NW), .N_RD(NR), .RETIRE_W(RW)) bus ();

    rob_multiport #(.N_ENTRIES(NE), .N_WB(NW), .N_RD(NR), .RETIRE_W(RW)) dut (
        .clk(clk), .rst_aH(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: queue of in-flight instructions, oldest first.
    typedef struct {
        int          id;
        bit          dv;
        int          arf;
        bit          st;
        logic [31:0] npc;
        logic [31:0] data;
        bit          ex;
        bit          mp;
    } m_t;
    m_t mq[$];
    int next_id = 0;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            next_id = 0;
        end else begin
            int          cnt, nret, hit;
            bit          redir, rdy;
            logic [31:0] rpc, rdat;
            logic [RW-1:0] rv, aw, sc;
            cnt = mq.size(); nret = 0; redir = 0; rpc = '0; rv = '0; aw = '0; sc = '0;
            for (int k = 0; k < RW; k++) begin
                if (k < cnt && mq[k].ex) begin
                    rv[k] = 1'b1; aw[k] = mq[k].dv; sc[k] = mq[k].st; nret++;
                    chk("m_arf_id", 64'(bus.retire_arf_id[k]), 64'(mq[k].arf));
                    chk("m_ret_data", 64'(bus.retire_reg_data[k]), 64'(mq[k].data));
                    if (mq[k].mp) begin redir = 1; rpc = mq[k].npc; break; end
                end else break;
            end
            chk("m_retire_valid", 64'(bus.retire_valid), 64'(rv));
            chk("m_arf_wr", 64'(bus.retire_arf_wr), 64'(aw));
            chk("m_st_commit", 64'(bus.st_commit), 64'(sc));
            chk("m_redirect", 64'(bus.redirect_valid), 64'(redir));
            if (redir) chk("m_redirect_pc", 64'(bus.redirect_pc), 64'(rpc));
            chk("m_disp_ready", 64'(bus.dispatch_ready), 64'((cnt < NE) && !redir));
            chk("m_disp_id", 64'(bus.dispatch_rob_id), 64'(next_id));
            for (int r = 0; r < NR; r++) begin
                hit = 0; rdy = 0; rdat = '0;
                for (int j = 0; j < cnt; j++)
                    if (mq[j].id == int'(bus.rd_rob_id[r])) begin hit = 1; rdy = mq[j].ex; rdat = mq[j].data; end
                for (int p = 0; p < NW; p++)
                    if (bus.wb_valid[p] && bus.wb_rob_id[p] == bus.rd_rob_id[r]) begin
                        hit = 1; rdy = 1; rdat = bus.wb_reg_data[p];
                    end
                if (hit) begin
                    chk("m_rd_ready", 64'(bus.rd_ready[r]), 64'(rdy));
                    if (rdy) chk("m_rd_data", 64'(bus.rd_reg_data[r]), 64'(rdat));
                end
            end
            if (redir) begin
                mq.delete();
                next_id = 0;
            end else begin
                for (int p = 0; p < NW; p++)
                    if (bus.wb_valid[p])
                        for (int j = 0; j < cnt; j++)
                            if (mq[j].id == int'(bus.wb_rob_id[p])) begin
                                mq[j].ex = 1; mq[j].data = bus.wb_reg_data[p];
                                if (bus.wb_npc_valid[p]) begin
                                    mq[j].npc = bus.wb_npc[p]; mq[j].mp = bus.wb_npc_mispred[p];
                                end
                            end
                for (int k = 0; k < nret; k++) void'(mq.pop_front());
                if (bus.dispatch_valid && cnt < NE) begin
                    m_t e;
                    e.id = next_id; e.dv = bus.dispatch_data.dst_valid;
                    e.arf = int'(bus.dispatch_data.dst_arf_id); e.st = bus.dispatch_data.is_store;
                    e.npc = bus.dispatch_data.pc; e.data = '0; e.ex = 0; e.mp = 0;
                    mq.push_back(e);
                    next_id = (next_id + 1) % NE;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dispatch_valid = 1'b0;
        bus.wb_valid       = '0;
        bus.wb_npc_valid   = '0;
        bus.wb_npc_mispred = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic enq(input bit dv, input int arf, input bit st, input logic [31:0] pc);
        bus.dispatch_valid = 1'b1;
        bus.dispatch_data  = '{dst_valid: dv, dst_arf_id: 5'(arf), is_store: st, pc: pc};
    endtask

    task automatic wb(input int p, input int id, input logic [31:0] d);
        bus.wb_valid[p]    = 1'b1;
        bus.wb_rob_id[p]   = 4'(id);
        bus.wb_reg_data[p] = d;
    endtask

    int pulses;

    initial begin
        idle();
        bus.dispatch_data = '0;
        bus.wb_rob_id = '0; bus.wb_reg_data = '0; bus.wb_npc = '0;
        bus.rd_rob_id = '0;
        step(); #1;
        chk("rst_ready", 64'(bus.dispatch_ready), 64'd1);
        chk("rst_id", 64'(bus.dispatch_rob_id), 64'd0);
        chk("rst_retire", 64'(bus.retire_valid), 64'd0);
        chk("rst_redirect", 64'(bus.redirect_valid), 64'd0);
        chk("rst_rd_ready", 64'(bus.rd_ready), 64'd0);
        step(); rst = 1'b0;

        // 1: fill to capacity
        for (int i = 0; i < NE; i++) begin
            enq(1, i, 0, 32'(i * 4)); #1;
            chk("t1_id", 64'(bus.dispatch_rob_id), 64'(i));
            chk("t1_ready", 64'(bus.dispatch_ready), 64'd1);
            step();
        end
        #1; chk("t1_full", 64'(bus.dispatch_ready), 64'd0);
        step(); #1;
        chk("t1_17th", 64'(bus.dispatch_ready), 64'd0);
        chk("t1_id_hold", 64'(bus.dispatch_rob_id), 64'd0);

        // 2: paired retire after out-of-order wb, then a single
        do_reset();
        for (int i = 0; i < 4; i++) begin enq(1, 10 + i, 0, 32'h100 + 32'(i)); step(); end
        idle(); wb(0, 1, 32'hA); wb(1, 0, 32'hB); #1;
        chk("t2_same_cycle", 64'(bus.retire_valid), 64'd0);
        step(); idle(); #1;
        chk("t2_rv", 64'(bus.retire_valid), 64'b11);
        chk("t2_d0", 64'(bus.retire_reg_data[0]), 64'hB);
        chk("t2_d1", 64'(bus.retire_reg_data[1]), 64'hA);
        chk("t2_arf0", 64'(bus.retire_arf_id[0]), 64'd10);
        step(); wb(0, 2, 32'hC); #1;
        chk("t2_wait", 64'(bus.retire_valid), 64'd0);
        step(); idle(); #1;
        chk("t2_single", 64'(bus.retire_valid), 64'b01);
        chk("t2_dc", 64'(bus.retire_reg_data[0]), 64'hC);

        // 3: younger done first blocks nothing until older complete
        do_reset();
        for (int i = 0; i < 4; i++) begin enq(0, 0, 0, 32'h200); step(); end
        idle(); wb(0, 3, 32'h33); step(); idle(); step(); #1;
        chk("t3_blocked", 64'(bus.retire_valid), 64'd0);
        wb(0, 0, 32'h30); wb(1, 1, 32'h31); wb(2, 2, 32'h32); step(); idle(); #1;
        chk("t3_rv_a", 64'(bus.retire_valid), 64'b11);
        chk("t3_d_a", 64'(bus.retire_reg_data[1]), 64'h31);
        step(); #1;
        chk("t3_rv_b", 64'(bus.retire_valid), 64'b11);
        chk("t3_d_b", 64'(bus.retire_reg_data[1]), 64'h33);
        step(); #1;
        chk("t3_empty", 64'(bus.retire_valid), 64'd0);
        chk("t3_id", 64'(bus.dispatch_rob_id), 64'd4);

        // 4: mispredict redirect and flush
        do_reset();
        enq(1, 7, 0, 32'h40); step(); enq(1, 8, 0, 32'h44); step(); idle();
        wb(0, 0, 32'h55); bus.wb_npc_valid[0] = 1'b1; bus.wb_npc_mispred[0] = 1'b1; bus.wb_npc[0] = 32'h80;
        wb(1, 1, 32'h66); step(); idle(); enq(1, 9, 0, 32'h48); #1;
        chk("t4_rv", 64'(bus.retire_valid), 64'b01);
        chk("t4_arf_wr", 64'(bus.retire_arf_wr), 64'b01);
        chk("t4_arf_id", 64'(bus.retire_arf_id[0]), 64'd7);
        chk("t4_redirect", 64'(bus.redirect_valid), 64'd1);
        chk("t4_pc", 64'(bus.redirect_pc), 64'h80);
        chk("t4_blocked", 64'(bus.dispatch_ready), 64'd0);
        step(); idle(); #1;
        chk("t4_ready", 64'(bus.dispatch_ready), 64'd1);
        chk("t4_id0", 64'(bus.dispatch_rob_id), 64'd0);
        chk("t4_flushed", 64'(bus.retire_valid), 64'd0);

        // 5: read bypass then state
        do_reset();
        for (int i = 0; i < 6; i++) begin enq(0, 0, 0, 32'h300); step(); end
        idle(); bus.rd_rob_id[0] = 4'd5; bus.rd_rob_id[1] = 4'd4; wb(2, 5, 32'h1234); #1;
        chk("t5_byp_rdy", 64'(bus.rd_ready[0]), 64'd1);
        chk("t5_byp_data", 64'(bus.rd_reg_data[0]), 64'h1234);
        chk("t5_not_ready", 64'(bus.rd_ready[1]), 64'd0);
        step(); idle(); #1;
        chk("t5_state_rdy", 64'(bus.rd_ready[0]), 64'd1);
        chk("t5_state_data", 64'(bus.rd_reg_data[0]), 64'h1234);

        // 6: wrap-around stream, one store, then async reset with 8 in flight
        do_reset();
        for (int c = 0; c < 31; c++) begin
            idle();
            enq(1, c % 32, (c == 30), 32'h1000 + 32'(c));
            if (c > 0) wb(0, (c - 1) % NE, 32'(c));
            step();
        end
        idle(); wb(0, 14, 32'h5707); step(); idle();
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            #1; if (bus.st_commit != '0) pulses++;
            step();
        end
        chk("t6_st_pulses", 64'(pulses), 64'd1);
        for (int i = 0; i < 8; i++) begin enq(0, 0, 0, 32'h2000); step(); end
        idle(); bus.rd_rob_id[0] = 4'd14; #1;
        chk("t6_pre_id", 64'(bus.dispatch_rob_id), 64'd7);
        chk("t6_pre_rd", 64'(bus.rd_ready[0]), 64'd1);
        rst = 1'b1; #1;
        chk("t6_async_ready", 64'(bus.dispatch_ready), 64'd1);
        chk("t6_async_id", 64'(bus.dispatch_rob_id), 64'd0);
        chk("t6_async_rv", 64'(bus.retire_valid), 64'd0);
        chk("t6_async_sc", 64'(bus.st_commit), 64'd0);
        chk("t6_async_redir", 64'(bus.redirect_valid), 64'd0);
        chk("t6_async_rd", 64'(bus.rd_ready), 64'd0);
        step(); step(); rst = 1'b0; #1;
        chk("t6_post_id", 64'(bus.dispatch_rob_id), 64'd0);
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
